// File: rtl/hdu_scoreboard_if.sv
// Hazard-detection scoreboard bus.
// Groups the pipeline-side signals of hdu_scoreboard so that the pipeline
// (master) and the scoreboard (slave) share a single connection.
//   id_ex_memRead, id_ex_rt : load currently in EX and its destination
//   instruction2msb_in      : {opcode[5:0], rs[4:0], rt[4:0]} of the ID instruction
//   mem_ready_in            : data memory ready, 0 freezes the pipeline
//   clear_count_in          : synchronous clear of the stall counter
//   pc_wr_out, if_id_wr_out : PC and IF/ID write enables
//   flush_control_out       : bubble insert into ID/EX
//   state_out               : registered FSM state (0 RUN, 1 LOAD_STALL, 2 MEM_WAIT)
//   stall_count_out         : saturating count of load-use stall cycles
interface hdu_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_ex_memRead;
  logic [REG_W-1:0] id_ex_rt;
  logic [15:0]      instruction2msb_in;
  logic             mem_ready_in;
  logic             clear_count_in;
  logic             pc_wr_out;
  logic             if_id_wr_out;
  logic             flush_control_out;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] stall_count_out;

  modport master (
    output id_ex_memRead, id_ex_rt, instruction2msb_in, mem_ready_in, clear_count_in,
    input  pc_wr_out, if_id_wr_out, flush_control_out, state_out, stall_count_out
  );

  modport slave (
    input  id_ex_memRead, id_ex_rt, instruction2msb_in, mem_ready_in, clear_count_in,
    output pc_wr_out, if_id_wr_out, flush_control_out, state_out, stall_count_out
  );
endinterface

// File: rtl/hdu_scoreboard.sv
// Load-use hazard detection unit with a producer scoreboard.
// A load in EX plus the loads of the last LOAD_LAT-1 advancing cycles form
// the producer set; an ID instruction reading one of those registers stalls
// the front end and inserts a bubble. A memory-not-ready cycle freezes the
// whole pipeline instead (no bubble, scoreboard held).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   hif   : hdu_scoreboard_if.slave (see interface header for signal list)
// Parameters: REG_W register-address width, LOAD_LAT load-use distance (1..4),
//   CNT_W stall-counter width, BRANCH_ONLY=1 limits checking to beq (opcode 4).
module hdu_scoreboard #(
  parameter int REG_W       = 5,
  parameter int LOAD_LAT    = 1,
  parameter int CNT_W       = 16,
  parameter int BRANCH_ONLY = 0
) (
  input  logic               clock,
  input  logic               reset,
  hdu_scoreboard_if.slave    hif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam int PD = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [5:0]       opcode;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             uses_rs;
  logic             uses_rt;
  logic             ex_vld;
  logic             ex_hit_rs;
  logic             ex_hit_rt;
  logic             pend_hit_rs;
  logic             pend_hit_rt;
  logic             hazard_any;
  logic             hazard;

  state_t           state_q;
  state_t           state_d;
  logic             pc_wr;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  // ---- ID decode and EX-stage producer ----
  assign opcode  = hif.instruction2msb_in[15:10];
  assign id_rs   = REG_W'(hif.instruction2msb_in[9:5]);
  assign id_rt   = REG_W'(hif.instruction2msb_in[4:0]);
  assign uses_rs = !((opcode == 6'd2) || (opcode == 6'd3));
  assign uses_rt = (opcode == 6'd0) || (opcode == 6'd4) || (opcode == 6'd5) || (opcode == 6'd43);

  // Register 0 is hardwired, so a load into it never produces anything.
  assign ex_vld    = hif.id_ex_memRead && (hif.id_ex_rt != '0);
  assign ex_hit_rs = ex_vld && (hif.id_ex_rt == id_rs);
  assign ex_hit_rt = ex_vld && (hif.id_ex_rt == id_rt);

  // ---- pending-load shift register (loads past EX, still in flight) ----
  if (LOAD_LAT > 1) begin : g_pend
    logic [PD-1:0]    pend_vld;
    logic [REG_W-1:0] pend_reg [PD];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pend_vld <= '0;
      end else if (hif.mem_ready_in) begin
        pend_vld[0] <= ex_vld;
        for (int i = 1; i < PD; i++) pend_vld[i] <= pend_vld[i-1];
      end
    end

    // Register fields need no reset: they are qualified by pend_vld.
    always_ff @(posedge clock) begin
      if (hif.mem_ready_in) begin
        pend_reg[0] <= hif.id_ex_rt;
        for (int i = 1; i < PD; i++) pend_reg[i] <= pend_reg[i-1];
      end
    end

    always_comb begin
      pend_hit_rs = 1'b0;
      pend_hit_rt = 1'b0;
      for (int i = 0; i < PD; i++) begin
        if (pend_vld[i] && (pend_reg[i] != '0) && (pend_reg[i] == id_rs)) pend_hit_rs = 1'b1;
        if (pend_vld[i] && (pend_reg[i] != '0) && (pend_reg[i] == id_rt)) pend_hit_rt = 1'b1;
      end
    end
  end else begin : g_no_pend
    assign pend_hit_rs = 1'b0;
    assign pend_hit_rt = 1'b0;
  end

  assign hazard_any = (uses_rs && (ex_hit_rs || pend_hit_rs)) ||
                      (uses_rt && (ex_hit_rt || pend_hit_rt));
  assign hazard     = (BRANCH_ONLY != 0) ? (hazard_any && (opcode == 6'd4)) : hazard_any;

  // ---- control FSM ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // A memory freeze outranks a hazard: nothing moves, so no bubble either.
  always_comb begin
    state_d = RUN;
    pc_wr   = 1'b1;
    flush   = 1'b0;
    if (!hif.mem_ready_in) begin
      state_d = MEM_WAIT;
      pc_wr   = 1'b0;
    end else if (hazard) begin
      state_d = LOAD_STALL;
      pc_wr   = 1'b0;
      flush   = 1'b1;
    end
  end

  // ---- stall statistics ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   stall_cnt <= '0;
    else if (hif.clear_count_in) stall_cnt <= '0;
    else if (flush)              stall_cnt <= sat_inc(stall_cnt);
  end

  assign hif.pc_wr_out         = pc_wr;
  assign hif.if_id_wr_out      = pc_wr;
  assign hif.flush_control_out = flush;
  assign hif.state_out         = state_q;
  assign hif.stall_count_out   = stall_cnt;

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Bench for hdu_scoreboard: four instances with different parameter sets
// share one stimulus stream and are compared every cycle against a
// behavioural model; directed sequences cover the multi-cycle corner cases.
//   k0: LOAD_LAT=1  k1: LOAD_LAT=3  k2: LOAD_LAT=3,BRANCH_ONLY=1  k3: LOAD_LAT=2,CNT_W=2
module tb_hdu_scoreboard;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst;
  logic        mr;
  logic [4:0]  rt;
  logic [15:0] instr;
  logic        rdy;
  logic        clr;

  int total = 0;
  int bad   = 0;

  hdu_scoreboard_if #(.REG_W(5), .CNT_W(16)) if0 ();
  hdu_scoreboard_if #(.REG_W(5), .CNT_W(16)) if1 ();
  hdu_scoreboard_if #(.REG_W(5), .CNT_W(16)) if2 ();
  hdu_scoreboard_if #(.REG_W(5), .CNT_W(2))  if3 ();

  assign if0.id_ex_memRead = mr;  assign if0.id_ex_rt = rt;  assign if0.instruction2msb_in = instr;
  assign if0.mem_ready_in  = rdy; assign if0.clear_count_in = clr;
  assign if1.id_ex_memRead = mr;  assign if1.id_ex_rt = rt;  assign if1.instruction2msb_in = instr;
  assign if1.mem_ready_in  = rdy; assign if1.clear_count_in = clr;
  assign if2.id_ex_memRead = mr;  assign if2.id_ex_rt = rt;  assign if2.instruction2msb_in = instr;
  assign if2.mem_ready_in  = rdy; assign if2.clear_count_in = clr;
  assign if3.id_ex_memRead = mr;  assign if3.id_ex_rt = rt;  assign if3.instruction2msb_in = instr;
  assign if3.mem_ready_in  = rdy; assign if3.clear_count_in = clr;

  hdu_scoreboard #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16), .BRANCH_ONLY(0)) u0 (.clock(clock), .reset(rst), .hif(if0));
  hdu_scoreboard #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16), .BRANCH_ONLY(0)) u1 (.clock(clock), .reset(rst), .hif(if1));
  hdu_scoreboard #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16), .BRANCH_ONLY(1)) u2 (.clock(clock), .reset(rst), .hif(if2));
  hdu_scoreboard #(.REG_W(5), .LOAD_LAT(2), .CNT_W(2),  .BRANCH_ONLY(0)) u3 (.clock(clock), .reset(rst), .hif(if3));

  logic        pc_a   [4];
  logic        ifid_a [4];
  logic        fl_a   [4];
  logic [1:0]  st_a   [4];
  logic [15:0] cnt_a  [4];

  assign pc_a[0] = if0.pc_wr_out; assign ifid_a[0] = if0.if_id_wr_out; assign fl_a[0] = if0.flush_control_out;
  assign pc_a[1] = if1.pc_wr_out; assign ifid_a[1] = if1.if_id_wr_out; assign fl_a[1] = if1.flush_control_out;
  assign pc_a[2] = if2.pc_wr_out; assign ifid_a[2] = if2.if_id_wr_out; assign fl_a[2] = if2.flush_control_out;
  assign pc_a[3] = if3.pc_wr_out; assign ifid_a[3] = if3.if_id_wr_out; assign fl_a[3] = if3.flush_control_out;
  assign st_a[0] = if0.state_out; assign st_a[1] = if1.state_out;
  assign st_a[2] = if2.state_out; assign st_a[3] = if3.state_out;
  assign cnt_a[0] = if0.stall_count_out; assign cnt_a[1] = if1.stall_count_out;
  assign cnt_a[2] = if2.stall_count_out; assign cnt_a[3] = {14'b0, if3.stall_count_out};

  // ---------------- behavioural reference ----------------
  // A register is a live producer if it is loaded in EX now, or was last
  // loaded 1..LOAD_LAT-1 advancing cycles ago.
  int last_ld [4][32];
  int adv     [4];
  int mcnt    [4];
  int mst     [4];

  function automatic int ll_of(input int k);
    case (k)
      0: return 1;
      1: return 3;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int cmax(input int k);
    return (k == 3) ? 3 : 65535;
  endfunction

  function automatic bit prod(input int k, input int r);
    int age;
    if (r == 0) return 1'b0;
    if (mr && (int'(rt) == r)) return 1'b1;
    age = adv[k] - last_ld[k][r];
    return (age >= 1) && (age <= ll_of(k) - 1);
  endfunction

  function automatic bit m_hazard(input int k);
    int op, rs, rd;
    bit urs, urt, h;
    op  = int'(instr[15:10]);
    rs  = int'(instr[9:5]);
    rd  = int'(instr[4:0]);
    urs = !(op == 2 || op == 3);
    urt = (op == 0 || op == 4 || op == 5 || op == 43);
    h   = (urs && prod(k, rs)) || (urt && prod(k, rd));
    if (k == 2 && op != 4) h = 1'b0;
    return h;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 32; r++) last_ld[k][r] = -1000;
      adv[k]  = 0;
      mcnt[k] = 0;
      mst[k]  = 0;
    end
  endtask

  task automatic m_edge();
    bit h, f;
    if (rst) return;
    for (int k = 0; k < 4; k++) begin
      h = m_hazard(k);
      f = rdy && h;
      mst[k] = !rdy ? 2 : (h ? 1 : 0);
      if (clr) mcnt[k] = 0;
      else if (f && mcnt[k] < cmax(k)) mcnt[k] = mcnt[k] + 1;
      if (rdy) begin
        if (mr && rt != 5'd0) last_ld[k][int'(rt)] = adv[k];
        adv[k] = adv[k] + 1;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%0d want=%0d t=%0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    bit h;
    for (int k = 0; k < 4; k++) begin
      h = m_hazard(k);
      check("pc_wr",   k, int'(pc_a[k]),   int'(rdy && !h));
      check("if_id_wr",k, int'(ifid_a[k]), int'(rdy && !h));
      check("flush",   k, int'(fl_a[k]),   int'(rdy && h));
      check("state",   k, int'(st_a[k]),   mst[k]);
      check("count",   k, int'(cnt_a[k]),  mcnt[k]);
    end
  endtask

  task automatic apply(input logic a_mr, input logic [4:0] a_rt, input logic [15:0] a_in,
                       input logic a_rdy, input logic a_clr, input logic a_rst);
    mr = a_mr; rt = a_rt; instr = a_in; rdy = a_rdy; clr = a_clr; rst = a_rst;
    if (a_rst) m_reset();
    #1;
    cmp_all();
  endtask

  task automatic tick();
    @(posedge clock);
    m_edge();
    @(negedge clock);
  endtask

  task automatic do_reset();
    apply(1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b1);
    tick();
  endtask

  function automatic logic [15:0] mk(input int op, input int rs, input int rd);
    return {op[5:0], rs[4:0], rd[4:0]};
  endfunction

  // Load in EX for one cycle, then bubbles, with the dependent ID instruction held.
  logic       fl_h [4][8];
  logic       pc_h [4][8];
  logic [1:0] st_h [4][8];
  int         cnt_h[4][8];

  task automatic run_dep(input logic [4:0] r, input logic [15:0] ins, input int n);
    for (int c = 0; c < n; c++) begin
      apply(c == 0, r, ins, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
        fl_h[k][c]  = fl_a[k];
        pc_h[k][c]  = pc_a[k];
        st_h[k][c]  = st_a[k];
        cnt_h[k][c] = int'(cnt_a[k]);
      end
      tick();
    end
  endtask

  function automatic int nflush(input int k, input int n);
    int s = 0;
    for (int c = 0; c < n; c++) s += int'(fl_h[k][c]);
    return s;
  endfunction

  typedef struct {
    logic        mr;
    logic [4:0]  rt;
    logic [15:0] ins;
    logic        rdy;
    logic        pc;
    logic        fl;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int op_set [8];
    tbl[0]  = '{1'b1, 5'd8, mk(0, 8, 1),  1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 5'd8, mk(0, 1, 8),  1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 5'd0, mk(0, 0, 0),  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 5'd8, mk(2, 8, 8),  1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 5'd8, mk(3, 8, 8),  1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 5'd8, mk(8, 1, 8),  1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 5'd8, mk(8, 8, 1),  1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 5'd8, mk(0, 8, 8),  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 5'd8, mk(0, 8, 1),  1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 5'd9, mk(43, 1, 9), 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 5'd9, mk(35, 1, 9), 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 5'd9, mk(5, 2, 9),  1'b1, 1'b0, 1'b1};
    op_set = '{0, 2, 3, 4, 5, 43, 8, 35};

    mr = 1'b0; rt = 5'd0; instr = 16'd0; rdy = 1'b1; clr = 1'b0; rst = 1'b1;
    @(negedge clock);
    m_reset();

    // reset state
    apply(1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("rst_state", k, int'(st_a[k]), 0);
      check("rst_count", k, int'(cnt_a[k]), 0);
    end
    tick();

    // combinational truth table on the LOAD_LAT=1 instance
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].mr, tbl[i].rt, tbl[i].ins, tbl[i].rdy, 1'b1, 1'b0);
      check("tbl_pc",    i, int'(pc_a[0]),   int'(tbl[i].pc));
      check("tbl_if_id", i, int'(ifid_a[0]), int'(tbl[i].pc));
      check("tbl_flush", i, int'(fl_a[0]),   int'(tbl[i].fl));
      tick();
    end

    // single-cycle load-use on LOAD_LAT=1
    do_reset();
    run_dep(5'd8, mk(0, 8, 1), 3);
    check("ll1_flush_c0", 0, int'(fl_h[0][0]), 1);
    check("ll1_pc_c0",    0, int'(pc_h[0][0]), 0);
    check("ll1_flush_c1", 0, int'(fl_h[0][1]), 0);
    check("ll1_pc_c1",    0, int'(pc_h[0][1]), 1);
    check("ll1_cnt_c0",   0, cnt_h[0][0], 0);
    check("ll1_cnt_c1",   0, cnt_h[0][1], 1);

    // store after load, per-latency stall length
    do_reset();
    run_dep(5'd9, mk(43, 1, 9), 6);
    check("sw_nflush", 0, nflush(0, 6), 1);
    check("sw_nflush", 1, nflush(1, 6), 3);
    check("sw_nflush", 2, nflush(2, 6), 0);
    check("sw_nflush", 3, nflush(3, 6), 2);
    check("sw_flush_c2", 1, int'(fl_h[1][2]), 1);
    check("sw_pc_c3",    1, int'(pc_h[1][3]), 1);
    check("sw_state_c1", 1, int'(st_h[1][1]), 1);
    check("sw_state_c3", 1, int'(st_h[1][3]), 1);
    check("sw_state_c4", 1, int'(st_h[1][4]), 0);
    check("sw_count",    1, int'(cnt_a[1]), 3);
    check("sw_count",    3, int'(cnt_a[3]), 2);

    // branch-only gating
    do_reset();
    run_dep(5'd7, mk(0, 7, 0), 5);
    check("bo_alu_nflush", 2, nflush(2, 5), 0);
    check("bo_alu_nflush", 1, nflush(1, 5), 3);
    do_reset();
    run_dep(5'd7, mk(4, 7, 0), 5);
    check("bo_beq_nflush", 2, nflush(2, 5), 3);

    // memory freeze over a pending hazard
    do_reset();
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 5'd6, mk(0, 6, 0), 1'b0, 1'b0, 1'b0);
      check("frz_flush", 1, int'(fl_a[1]), 0);
      check("frz_pc",    1, int'(pc_a[1]), 0);
      if (c == 1) check("frz_state", 1, int'(st_a[1]), 2);
      tick();
    end
    run_dep(5'd6, mk(0, 6, 0), 6);
    check("frz_state_c0", 1, int'(st_h[1][0]), 2);
    check("frz_nflush",   1, nflush(1, 6), 3);
    check("frz_count",    1, int'(cnt_a[1]), 3);
    check("frz_count",    3, int'(cnt_a[3]), 2);

    // saturation, clear-vs-increment, reset mid-stall (CNT_W=2 instance)
    do_reset();
    run_dep(5'd5, mk(0, 5, 0), 3);
    run_dep(5'd5, mk(0, 5, 0), 3);
    apply(1'b1, 5'd5, mk(0, 5, 0), 1'b1, 1'b0, 1'b0);
    tick();
    check("sat_count", 3, int'(cnt_a[3]), 3);
    check("sat_count", 1, int'(cnt_a[1]), 7);
    apply(1'b1, 5'd5, mk(0, 5, 0), 1'b1, 1'b1, 1'b0);
    check("clr_flush", 3, int'(fl_a[3]), 1);
    tick();
    apply(1'b0, 5'd0, mk(0, 5, 0), 1'b1, 1'b0, 1'b0);
    check("clr_count",    3, int'(cnt_a[3]), 0);
    check("pend_flush",   3, int'(fl_a[3]), 1);
    apply(1'b0, 5'd0, mk(0, 5, 0), 1'b1, 1'b0, 1'b1);
    check("rst_mid_pc",   3, int'(pc_a[3]), 1);
    check("rst_mid_pc",   1, int'(pc_a[1]), 1);
    check("rst_mid_flush",3, int'(fl_a[3]), 0);
    tick();
    apply(1'b0, 5'd0, mk(0, 5, 0), 1'b1, 1'b0, 1'b0);
    check("post_rst_pc",  3, int'(pc_a[3]), 1);
    check("post_rst_pc",  1, int'(pc_a[1]), 1);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      apply($urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)),
            mk(op_set[$urandom_range(0, 7)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
            $urandom_range(0, 99) < 85,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 63) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdu_scoreboard.md
HDU_SCOREBOARD -- requirements
Module: hdu_scoreboard

Interface
REQ-001 Parameter REG_W, default 5, meaning register-address width.
REQ-002 Parameter LOAD_LAT, default 1, meaning load-use distance in cycles; the legal range is 1..4.
REQ-003 Parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 Parameter BRANCH_ONLY, default 0, meaning that 1 restricts the hazard check to ID opcode 4 (beq); 0 checks every source-using opcode.
REQ-005 clock  in  1  sole clock; all state updates occur on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 id_ex_memRead  in  1  the instruction in EX is a load.
REQ-008 id_ex_rt  in  REG_W  destination register of the EX load.
REQ-009 instruction2msb_in  in  16  bits [15:10] are the opcode, [9:5] are rs, [4:0] are rt of the ID instruction.
REQ-010 mem_ready_in  in  1  data memory ready; 0 freezes the pipeline.
REQ-011 clear_count_in  in  1  synchronous clear of the stall counter.
REQ-012 pc_wr_out, if_id_wr_out  out  1 each  PC and IF/ID write enables.
REQ-013 flush_control_out  out  1  zeroes ID/EX control (bubble insert).
REQ-014 state_out  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT.
REQ-015 stall_count_out  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-016 uses_rs SHALL be 1 unless the opcode is 2 or 3; uses_rt SHALL be 1 only for opcodes 0, 4, 5 and 43.
REQ-017 Producer set = {id_ex_rt when id_ex_memRead=1} plus the valid entries pend[0..LOAD_LAT-2]. Entries whose register is 0 never match.
REQ-018 hazard SHALL assert when (uses_rs and rs matches a producer) or (uses_rt and rt matches a producer); with BRANCH_ONLY=1 it is additionally gated by opcode==4.
REQ-019 pend SHALL be a LOAD_LAT-1 deep shift register of {valid, reg}; with LOAD_LAT=1 it has no storage.
REQ-020 When mem_ready_in=1, each rising edge SHALL load pend[0] with {id_ex_memRead && id_ex_rt!=0, id_ex_rt} and shift pend[i] into pend[i+1], dropping the last entry.
REQ-021 When mem_ready_in=0, pend SHALL hold.
REQ-022 Outputs are combinational from the current inputs and pend:
- mem_ready_in=0 → pc_wr=0, if_id_wr=0, flush=0 (freeze, no bubble).
- mem_ready_in=1 and hazard → pc_wr=0, if_id_wr=0, flush=1.
- otherwise → pc_wr=1, if_id_wr=1, flush=0.
REQ-023 mem_ready_in=0 SHALL take priority over hazard in the same cycle.
REQ-024 The registered FSM next-state SHALL be MEM_WAIT if mem_ready_in=0, else LOAD_STALL if hazard, else RUN; every transition between any pair of states is legal.
REQ-025 state_out SHALL show the registered state, which reflects the previous cycle's condition.
REQ-026 stall_count_out SHALL increment by 1 on each edge where flush_control_out=1 and SHALL saturate at all-ones with no wrap.
REQ-027 clear_count_in=1 SHALL zero the counter on that edge, overriding a simultaneous increment.
REQ-028 A dependent instruction directly after a load SHALL see exactly LOAD_LAT stall cycles, provided mem_ready_in stays 1; cycles with mem_ready_in=0 extend the stall and are not counted.

Reset
REQ-029 While reset=1, the block SHALL asynchronously force all pend valid bits to 0, state to RUN and stall_count_out to 0.
REQ-030 While reset=1, the combinational outputs SHALL still follow REQ-022.
REQ-031 Reset asserted mid-stall SHALL discard the pending producers; after release, only id_ex inputs can create a hazard.

Verification
REQ-032 LOAD_LAT=1: load rt=8 in EX, ID instruction opcode 0 with rs=8 → exactly 1 cycle of pc_wr=0, flush=1; stall_count_out 0→1.
REQ-033 LOAD_LAT=3: load rt=9 then ID instruction opcode 43 with rt=9 → 3 consecutive flush cycles, state_out=1 during the stall, count=3, then pc_wr=1.
REQ-034 Load with rt=0 and ID rs=0 → no stall; opcode 2 with rs=rt=load destination → no stall.
REQ-035 BRANCH_ONLY=1: dependent opcode 0 → no stall; dependent opcode 4 → stall.
REQ-036 Hazard present with mem_ready_in=0 for 2 cycles → flush=0 and state_out=2 for those cycles, pend held; after mem_ready_in=1, the full LOAD_LAT stall occurs and the count increases by LOAD_LAT only.
REQ-037 CNT_W=2: 5 stall cycles → count saturates at 3; clear_count_in together with a stall → 0; reset pulse mid-stall → pc_wr=1 once the id_ex inputs are idle.
